// File: rtl/display_pkg.sv
// Shared types and constants for the display code sequencer and its helpers.
package display_pkg;

    localparam int CODE_W = 5;

    typedef enum logic [1:0] {
        MANUAL     = 2'd0,
        AUTO_RUN   = 2'd1,
        AUTO_PAUSE = 2'd2
    } seq_state_t;

    // Bit positions of each decoder input within the code word.
    localparam int C1_IDX = 4;
    localparam int C2_IDX = 3;
    localparam int C3_IDX = 2;
    localparam int C4_IDX = 1;
    localparam int C6_IDX = 0;

endpackage

// File: rtl/display_code_sequencer_if.sv
// Board-side bundle of the sequencer: raw switch/button inputs and decoder-facing outputs.
interface display_code_sequencer_if;
    import display_pkg::*;

    logic [CODE_W-1:0] sw;
    logic              load_btn;
    logic              step_btn;
    logic              mode;
    logic              c1;
    logic              c2;
    logic              c3;
    logic              c4;
    logic              c6;
    logic              code_upd;
    logic              auto_led;

    modport master (
        output sw, load_btn, step_btn, mode,
        input  c1, c2, c3, c4, c6, code_upd, auto_led
    );

    modport slave (
        input  sw, load_btn, step_btn, mode,
        output c1, c2, c3, c4, c6, code_upd, auto_led
    );

endinterface

// File: rtl/display_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level debounce, and a one-cycle press pulse on acceptance.
module display_btn_debounce #(
    parameter int DEB_CYCLES = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    // NOTE: defaults first, so every path assigns every _d and no latch is inferred.
    always_comb begin
        sync_d  = {sync_q[0], raw};
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = level_d & ~level_q;
    end

    // NOTE: state flops take non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/display_code_sequencer.sv
// Produces the 5-bit 7-segment decoder code from switch loads, manual steps or an auto-step timer.
module display_code_sequencer
    import display_pkg::*;
#(
    parameter int DEB_CYCLES = 50_000,
    parameter int TICK_DIV   = 25_000_000
) (
    input logic                     clk,
    input logic                     rst_n,
    display_code_sequencer_if.slave bus
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic              load_press, step_press;
    logic              load_level, step_level;
    logic [CODE_W-1:0] sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic              mode_meta_q, mode_meta_d, mode_sync_q, mode_sync_d;
    seq_state_t        state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              code_upd_q, code_upd_d;

    display_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_load_deb (
        .clk(clk), .rst_n(rst_n), .raw(bus.load_btn), .level(load_level), .press(load_press)
    );

    display_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
        .clk(clk), .rst_n(rst_n), .raw(bus.step_btn), .level(step_level), .press(step_press)
    );

    // Priority within a cycle: load, then step, then tick; at most one code write.
    always_comb begin
        sw_meta_d   = bus.sw;
        sw_sync_d   = sw_meta_q;
        mode_meta_d = bus.mode;
        mode_sync_d = mode_meta_q;
        state_d     = state_q;
        tick_d      = tick_q;
        code_d      = code_q;
        code_upd_d  = 1'b0;

        if (load_press) begin
            code_d     = sw_sync_q;
            code_upd_d = 1'b1;
            tick_d     = '0;
        end

        if (!mode_sync_q) begin
            // Leaving auto drops any same-cycle tick; steps only count in MANUAL.
            state_d = MANUAL;
            tick_d  = '0;
            if (!load_press && step_press && state_q == MANUAL) begin
                code_d     = code_q + CODE_W'(1);
                code_upd_d = 1'b1;
            end
        end else begin
            case (state_q)
                MANUAL: begin
                    state_d = AUTO_RUN;
                    tick_d  = '0;
                    if (!load_press && step_press) begin
                        code_d     = code_q + CODE_W'(1);
                        code_upd_d = 1'b1;
                    end
                end
                AUTO_RUN: begin
                    if (!load_press) begin
                        if (step_press) begin
                            state_d = AUTO_PAUSE;
                        end else if (tick_q == TICK_LAST) begin
                            code_d     = code_q + CODE_W'(1);
                            code_upd_d = 1'b1;
                            tick_d     = '0;
                        end else begin
                            tick_d = tick_q + TICK_W'(1);
                        end
                    end
                end
                AUTO_PAUSE: begin
                    if (!load_press && step_press) begin
                        state_d = AUTO_RUN;
                    end
                end
                default: state_d = MANUAL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            mode_meta_q <= 1'b0;
            mode_sync_q <= 1'b0;
            state_q     <= MANUAL;
            tick_q      <= '0;
            code_q      <= '0;
            code_upd_q  <= 1'b0;
        end else begin
            sw_meta_q   <= sw_meta_d;
            sw_sync_q   <= sw_sync_d;
            mode_meta_q <= mode_meta_d;
            mode_sync_q <= mode_sync_d;
            state_q     <= state_d;
            tick_q      <= tick_d;
            code_q      <= code_d;
            code_upd_q  <= code_upd_d;
        end
    end

    assign bus.c1       = code_q[C1_IDX];
    assign bus.c2       = code_q[C2_IDX];
    assign bus.c3       = code_q[C3_IDX];
    assign bus.c4       = code_q[C4_IDX];
    assign bus.c6       = code_q[C6_IDX];
    assign bus.code_upd = code_upd_q;
    assign bus.auto_led = (state_q == AUTO_RUN);

endmodule

// File: tb/tb_display_code_sequencer.sv
// Directed bench for display_code_sequencer: reset, load/step table, auto run/pause, collisions, mode drop.
module tb_display_code_sequencer;
    import display_pkg::*;

    localparam int DEB = 4;
    localparam int DIV = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    display_code_sequencer_if bus();

    display_code_sequencer #(.DEB_CYCLES(DEB), .TICK_DIV(DIV)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;

    typedef struct {
        logic [4:0] sw;
        logic       load;
        logic       step;
        int         hold;
        logic [4:0] exp_code;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [4:0] code_out();
        return {bus.c1, bus.c2, bus.c3, bus.c4, bus.c6};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are observed on the falling edge.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.code_upd === 1'b1) upd_cnt++;
        end
    endtask

    task automatic press(input vec_t v, input int idx);
        upd_cnt      = 0;
        bus.sw       = v.sw;
        bus.load_btn = v.load;
        bus.step_btn = v.step;
        ticks(v.hold);
        bus.load_btn = 1'b0;
        bus.step_btn = 1'b0;
        ticks(10);
        check($sformatf("vec%0d_code", idx), 32'(code_out()), 32'(v.exp_code));
        check($sformatf("vec%0d_upd", idx), upd_cnt, 1);
    endtask

    initial begin
        bus.sw       = '0;
        bus.load_btn = 1'b0;
        bus.step_btn = 1'b0;
        bus.mode     = 1'b0;

        // Reset state
        @(negedge clk);
        ticks(2);
        check("rst_code", 32'(code_out()), 0);
        check("rst_upd", 32'(bus.code_upd), 0);
        check("rst_led", 32'(bus.auto_led), 0);
        rst_n = 1'b1;

        // Reset mid-debounce restarts the full latency
        bus.sw       = 5'd13;
        bus.load_btn = 1'b1;
        ticks(4);
        rst_n = 1'b0;
        #1;
        check("middeb_rst_code", 32'(code_out()), 0);
        @(negedge clk);
        rst_n   = 1'b1;
        upd_cnt = 0;
        ticks(6);
        check("deb_restart_early", 32'(code_out()), 0);
        ticks(1);
        check("deb_restart_load", 32'(code_out()), 13);
        check("deb_restart_upd", upd_cnt, 1);
        bus.load_btn = 1'b0;
        ticks(10);

        // Async reset with code=13 clears outputs immediately
        rst_n = 1'b0;
        #1;
        check("async_rst_code", 32'(code_out()), 0);
        check("async_rst_led", 32'(bus.auto_led), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(10);
        check("post_rst_code", 32'(code_out()), 0);

        // 3-clock glitch is rejected
        bus.sw       = 5'b10110;
        bus.load_btn = 1'b1;
        ticks(3);
        bus.load_btn = 1'b0;
        upd_cnt      = 0;
        ticks(10);
        check("glitch_code", 32'(code_out()), 0);
        check("glitch_upd", upd_cnt, 0);

        // Load latency exactly DEB+3 clocks
        bus.load_btn = 1'b1;
        upd_cnt      = 0;
        ticks(6);
        check("load_lat_early", 32'(code_out()), 0);
        ticks(1);
        check("load_lat_code", 32'(code_out()), 32'(5'b10110));
        check("load_c1", 32'(bus.c1), 1);
        check("load_c6", 32'(bus.c6), 0);
        ticks(3);
        bus.load_btn = 1'b0;
        ticks(10);
        check("load_upd_once", upd_cnt, 1);

        // Manual table: loads, steps, wrap, long hold, collision
        vecs[0] = '{5'd5,  1'b1, 1'b0, 8,  5'd5};
        vecs[1] = '{5'd5,  1'b0, 1'b1, 8,  5'd6};
        vecs[2] = '{5'd6,  1'b1, 1'b0, 8,  5'd6};
        vecs[3] = '{5'd31, 1'b1, 1'b0, 8,  5'd31};
        vecs[4] = '{5'd31, 1'b0, 1'b1, 40, 5'd0};
        vecs[5] = '{5'd9,  1'b1, 1'b1, 8,  5'd9};
        vecs[6] = '{5'd9,  1'b0, 1'b1, 8,  5'd10};
        vecs[7] = '{5'd2,  1'b1, 1'b0, 8,  5'd2};
        for (int i = 0; i < 8; i++) begin
            press(vecs[i], i);
        end

        // Auto run: increments at 8-clock spacing
        bus.mode = 1'b1;
        ticks(2);
        check("auto_led_early", 32'(bus.auto_led), 0);
        ticks(1);
        check("auto_led_on", 32'(bus.auto_led), 1);
        upd_cnt = 0;
        ticks(7);
        check("auto_pre3", 32'(code_out()), 2);
        ticks(1);
        check("auto_3", 32'(code_out()), 3);
        ticks(8);
        check("auto_4", 32'(code_out()), 4);
        ticks(8);
        check("auto_5", 32'(code_out()), 5);
        check("auto_upd3", upd_cnt, 3);

        // Pause with tick counter at 6
        bus.step_btn = 1'b1;
        ticks(6);
        check("pause_pre_led", 32'(bus.auto_led), 1);
        ticks(1);
        check("pause_led", 32'(bus.auto_led), 0);
        check("pause_code", 32'(code_out()), 5);
        ticks(3);
        bus.step_btn = 1'b0;
        upd_cnt      = 0;
        ticks(30);
        check("frozen_code", 32'(code_out()), 5);
        check("frozen_upd", upd_cnt, 0);

        // Resume from held phase: increment two clocks after resuming
        bus.step_btn = 1'b1;
        ticks(7);
        check("resume_led", 32'(bus.auto_led), 1);
        check("resume_code", 32'(code_out()), 5);
        ticks(1);
        check("resume_hold", 32'(code_out()), 5);
        ticks(1);
        check("resume_inc", 32'(code_out()), 6);
        bus.step_btn = 1'b0;

        // Load lands on a tick cycle: code=sw, no +1, counter restarts
        ticks(1);
        bus.sw       = 5'd17;
        bus.load_btn = 1'b1;
        upd_cnt      = 0;
        ticks(7);
        check("tick_load_code", 32'(code_out()), 17);
        check("tick_load_upd", upd_cnt, 1);
        ticks(1);
        bus.load_btn = 1'b0;
        ticks(6);
        check("tick_load_hold", 32'(code_out()), 17);
        ticks(1);
        check("tick_load_next", 32'(code_out()), 18);

        // Pause, then drop mode: MANUAL, code unchanged, no update
        bus.step_btn = 1'b1;
        ticks(7);
        check("pause2_led", 32'(bus.auto_led), 0);
        check("pause2_code", 32'(code_out()), 18);
        bus.step_btn = 1'b0;
        ticks(10);
        upd_cnt  = 0;
        bus.mode = 1'b0;
        ticks(5);
        check("drop_led", 32'(bus.auto_led), 0);
        check("drop_code", 32'(code_out()), 18);
        check("drop_upd", upd_cnt, 0);
        bus.step_btn = 1'b1;
        ticks(8);
        bus.step_btn = 1'b0;
        ticks(10);
        check("drop_manual_step", 32'(code_out()), 19);
        check("drop_manual_led", 32'(bus.auto_led), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
